// File: rtl/tsen_ctrl.sv
// TL-UL device-side controller for an on-die temperature sensor: small register
// file, one-shot/periodic conversion sequencer with timeout, and a level interrupt.

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

endpackage

module tsen_ctrl
  import tlul_pkg::*;
#(
  parameter int DataWidth     = 12,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  tl_h2d_t              tl_i,
  output tl_d2h_t              tl_o,
  output logic                 tsen_start_o,
  input  logic                 tsen_done_i,
  input  logic [DataWidth-1:0] tsen_data_i,
  output logic                 intr_tsen_o
);

  localparam int TcW  = $clog2(TimeoutCycles + 1);
  localparam int CntW = (TcW > 16) ? TcW : 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic                  r_start_o, r_start_req, r_intr;
  logic                  r_en, r_valid, r_timeout;
  logic [15:0]           r_period;
  logic [DataWidth-1:0]  r_data, r_thresh;
  logic [1:0]            r_intr_state, r_intr_en;
  logic                  r_d_valid, r_d_error;
  logic [2:0]            r_d_opcode;
  logic [1:0]            r_d_size;
  logic [7:0]            r_d_source;
  logic [31:0]           r_d_data;

  logic        w_a_ready, w_accept, w_is_get, w_is_put, w_op_ok, w_addr_ok, w_err;
  logic        w_wr, w_rd, w_busy, w_capture, w_timeout_set;
  logic        w_wr_ctrl, w_wr_status, w_wr_thresh, w_wr_istate, w_wr_ien, w_rd_data;
  logic        w_valid_nxt, w_timeout_nxt;
  logic [1:0]  w_intr_set, w_intr_clr, w_intr_state_nxt, w_intr_en_nxt;
  logic [5:0]  w_addr;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Request decode: anything outside full-word Get/Put to a mapped offset is an error
  assign w_addr    = tl_i.a_address[5:0];
  assign w_a_ready = !r_d_valid || tl_i.d_ready;
  assign w_accept  = tl_i.a_valid && w_a_ready;
  assign w_is_get  = (tl_i.a_opcode == Get);
  assign w_is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign w_op_ok   = (w_is_get || w_is_put) && (tl_i.a_size == 2'd2) && (tl_i.a_mask == 4'hF);
  assign w_addr_ok = (w_addr < 6'h18) && (w_addr[1:0] == 2'b00);
  assign w_err     = !(w_op_ok && w_addr_ok);
  assign w_wr      = w_accept && !w_err && w_is_put;
  assign w_rd      = w_accept && !w_err && w_is_get;
  assign w_unused  = ^tl_i;

  assign w_wr_ctrl   = w_wr && (w_addr == 6'h00);
  assign w_wr_status = w_wr && (w_addr == 6'h04);
  assign w_wr_thresh = w_wr && (w_addr == 6'h0C);
  assign w_wr_istate = w_wr && (w_addr == 6'h10);
  assign w_wr_ien    = w_wr && (w_addr == 6'h14);
  assign w_rd_data   = w_rd && (w_addr == 6'h08);
  assign w_busy      = (r_state == ST_START) || (r_state == ST_WAIT);

  // Read mux over pre-edge register values
  always_comb begin
    w_rdata = 32'd0;
    case (w_addr)
      6'h00:   w_rdata = {r_period, 14'd0, 1'b0, r_en};
      6'h04:   w_rdata = {29'd0, r_timeout, r_valid, w_busy};
      6'h08:   w_rdata = 32'(r_data);
      6'h0C:   w_rdata = 32'(r_thresh);
      6'h10:   w_rdata = {30'd0, r_intr_state};
      6'h14:   w_rdata = {30'd0, r_intr_en};
      default: w_rdata = 32'd0;
    endcase
  end

  // Conversion sequencer next state; r_cnt times WAIT upward and GAP downward
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_capture     = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_start_req || r_en) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = {CntW{1'b0}};
      end
      ST_WAIT: begin
        if (tsen_done_i) begin
          w_capture   = 1'b1;
          w_state_nxt = r_en ? ST_GAP : ST_IDLE;
          w_cnt_nxt   = CntW'(r_period);
        end else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      ST_GAP: begin
        if (r_start_req) begin
          w_state_nxt = ST_START;
        end else if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == {CntW{1'b0}}) begin
          w_state_nxt = ST_START;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status/interrupt next values: hardware set beats a same-cycle software clear
  always_comb begin
    w_intr_set       = {w_capture && (tsen_data_i > r_thresh), w_capture};
    w_intr_clr       = w_wr_istate ? tl_i.a_data[1:0] : 2'b00;
    w_intr_state_nxt = (r_intr_state & ~w_intr_clr) | w_intr_set;
    w_intr_en_nxt    = w_wr_ien ? tl_i.a_data[1:0] : r_intr_en;
    w_valid_nxt      = w_capture ? 1'b1 : (w_rd_data ? 1'b0 : r_valid);
    w_timeout_nxt    = w_timeout_set ? 1'b1
                     : ((w_wr_status && tl_i.a_data[2]) ? 1'b0 : r_timeout);
  end

  // Sequencer state and registered start pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CntW{1'b0}};
      r_start_o <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_start_o <= (w_state_nxt == ST_START);
    end
  end

  // Register file
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en         <= 1'b0;
      r_period     <= 16'd0;
      r_thresh     <= {DataWidth{1'b1}};
      r_data       <= {DataWidth{1'b0}};
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_intr_state <= 2'b00;
      r_intr_en    <= 2'b00;
      r_intr       <= 1'b0;
      r_start_req  <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= tl_i.a_data[0];
        r_period <= tl_i.a_data[31:16];
      end
      if (w_wr_thresh) begin
        r_thresh <= tl_i.a_data[DataWidth-1:0];
      end
      if (w_capture) begin
        r_data <= tsen_data_i;
      end
      r_valid      <= w_valid_nxt;
      r_timeout    <= w_timeout_nxt;
      r_intr_state <= w_intr_state_nxt;
      r_intr_en    <= w_intr_en_nxt;
      r_intr       <= |(w_intr_state_nxt & w_intr_en_nxt);
      r_start_req  <= w_wr_ctrl && tl_i.a_data[1] && !w_busy;
    end
  end

  // Response channel: loaded on acceptance, held until the host takes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_d_valid  <= 1'b0;
      r_d_error  <= 1'b0;
      r_d_opcode <= AccessAck;
      r_d_size   <= 2'd0;
      r_d_source <= 8'd0;
      r_d_data   <= 32'd0;
    end else if (w_accept) begin
      r_d_valid  <= 1'b1;
      r_d_error  <= w_err;
      r_d_opcode <= w_is_get ? AccessAckData : AccessAck;
      r_d_size   <= tl_i.a_size;
      r_d_source <= tl_i.a_source;
      r_d_data   <= w_rd ? w_rdata : 32'd0;
    end else if (tl_i.d_ready) begin
      r_d_valid <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = r_d_valid;
    tl_o.d_opcode = r_d_opcode;
    tl_o.d_param  = 3'd0;
    tl_o.d_size   = r_d_size;
    tl_o.d_source = r_d_source;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = r_d_data;
    tl_o.d_error  = r_d_error;
    tl_o.a_ready  = w_a_ready;
  end

  assign tsen_start_o = r_start_o;
  assign intr_tsen_o  = r_intr;

endmodule

// File: tb/tb_tsen_ctrl.sv
// Self-checking bench for tsen_ctrl: table-driven register vectors through a
// response scoreboard, plus directed conversion, timeout and collision sequences.

module tb_tsen_ctrl;
  import tlul_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  size;
    logic [31:0] exp_d;
    logic        exp_e;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    string       nm;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    int          c;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  tl_h2d_t     tl_h2d;
  tl_d2h_t     tl_d2h;
  logic        tsen_start, intr, tsen_done;
  logic        man_done = 1'b0;
  logic        model_done = 1'b0;
  logic        auto_en = 1'b0;
  logic [2:0]  sr = 3'b000;
  logic [11:0] man_data = 12'd0;
  logic [7:0]  tag = 8'd0;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  rsp_t        rsp_q[$];
  int          start_q[$];
  int          drained_c[$];
  vec_t        vecs[15];

  assign tsen_done = man_done | model_done;

  tsen_ctrl #(.DataWidth(12), .TimeoutCycles(1024)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tl_i         (tl_h2d),
    .tl_o         (tl_d2h),
    .tsen_start_o (tsen_start),
    .tsen_done_i  (tsen_done),
    .tsen_data_i  (man_data),
    .intr_tsen_o  (intr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response and start-pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && tl_d2h.d_valid && tl_h2d.d_ready) begin
      rsp_q.push_back('{tl_d2h.d_data, tl_d2h.d_error, tl_d2h.d_opcode,
                        tl_d2h.d_size, tl_d2h.d_source, cyc});
    end
    if (tsen_start) start_q.push_back(cyc);
  end

  // Sensor model: done three cycles after each start pulse
  always @(negedge clk) begin
    sr         <= {sr[1:0], tsen_start};
    model_done <= auto_en && sr[2];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tl_req(input logic [2:0] op, input logic [5:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [1:0] size, input logic [31:0] exp_d,
                        input logic exp_e, input string nm, output int acc);
    int w = 0;
    tag = tag + 8'd1;
    tl_h2d.a_valid   = 1'b1;
    tl_h2d.a_opcode  = op;
    tl_h2d.a_param   = 3'd0;
    tl_h2d.a_size    = size;
    tl_h2d.a_source  = tag;
    tl_h2d.a_address = {26'($urandom()), addr};
    tl_h2d.a_mask    = mask;
    tl_h2d.a_data    = data;
    exp_q.push_back('{exp_d, exp_e, (op == 3'd4) ? 3'd1 : 3'd0, size, tag, nm});
    @(negedge clk);
    while (!tl_d2h.a_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    acc = cyc;
    if (!tl_d2h.a_ready) begin
      n_total++;
      n_bad++;
      $display("FAIL accept_timeout %s: a_ready got 0 want 1", nm);
    end
    @(posedge clk);
    #1;
    tl_h2d.a_valid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp_d, input string nm);
    int acc;
    tl_req(3'd4, addr, 32'd0, 4'hF, 2'd2, exp_d, 1'b0, nm, acc);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data, input string nm);
    int acc;
    tl_req(3'd0, addr, data, 4'hF, 2'd2, 32'd0, 1'b0, nm, acc);
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int   w = 0;
    exp_t e;
    rsp_t r;
    while (rsp_q.size() < exp_q.size() && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (rsp_q.size() < exp_q.size()) begin
      n_total++;
      n_bad++;
      $display("FAIL rsp_timeout: got %0d responses want %0d", rsp_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rsp_q.pop_front();
      n_total++;
      if (r.data !== e.data || r.err !== e.err || r.op !== e.op || r.size !== e.size
          || r.src !== e.src) begin
        n_bad++;
        $display("FAIL %s: got data=%h err=%b op=%0d size=%0d src=%0d want data=%h err=%b op=%0d size=%0d src=%0d",
                 e.nm, r.data, r.err, r.op, r.size, r.src, e.data, e.err, e.op, e.size, e.src);
      end
      drained_c.push_back(r.c);
    end
    if (rsp_q.size() > 0) begin
      n_total++;
      n_bad++;
      $display("FAIL extra_rsp: got %0d unexpected responses want 0", rsp_q.size());
    end
    exp_q.delete();
    rsp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int w;
    int late;

    vecs[0]  = '{3'd4, 6'h0C, 32'h0,        4'hF, 2'd2, 32'h0000_0FFF, 1'b0, "get_thresh_rst"};
    vecs[1]  = '{3'd4, 6'h20, 32'h0,        4'hF, 2'd2, 32'h0,         1'b1, "get_unmapped"};
    vecs[2]  = '{3'd1, 6'h0C, 32'h123,      4'h3, 2'd2, 32'h0,         1'b1, "put_partial_mask"};
    vecs[3]  = '{3'd4, 6'h0C, 32'h0,        4'hF, 2'd2, 32'h0000_0FFF, 1'b0, "thresh_unchanged1"};
    vecs[4]  = '{3'd0, 6'h0C, 32'h55,       4'hF, 2'd1, 32'h0,         1'b1, "put_bad_size"};
    vecs[5]  = '{3'd4, 6'h0C, 32'h0,        4'hF, 2'd2, 32'h0000_0FFF, 1'b0, "thresh_unchanged2"};
    vecs[6]  = '{3'd2, 6'h00, 32'h0,        4'hF, 2'd2, 32'h0,         1'b1, "bad_opcode"};
    vecs[7]  = '{3'd4, 6'h00, 32'h0,        4'hF, 2'd2, 32'h0,         1'b0, "ctrl_rst"};
    vecs[8]  = '{3'd4, 6'h04, 32'h0,        4'hF, 2'd2, 32'h0,         1'b0, "status_rst"};
    vecs[9]  = '{3'd4, 6'h08, 32'h0,        4'hF, 2'd2, 32'h0,         1'b0, "data_rst"};
    vecs[10] = '{3'd4, 6'h10, 32'h0,        4'hF, 2'd2, 32'h0,         1'b0, "istate_rst"};
    vecs[11] = '{3'd0, 6'h14, 32'hFFFF_FFFF, 4'hF, 2'd2, 32'h0,        1'b0, "put_ien"};
    vecs[12] = '{3'd4, 6'h14, 32'h0,        4'hF, 2'd2, 32'h3,         1'b0, "ien_reserved"};
    vecs[13] = '{3'd1, 6'h14, 32'h0,        4'hF, 2'd2, 32'h0,         1'b0, "put_partial_full"};
    vecs[14] = '{3'd4, 6'h3C, 32'h0,        4'hF, 2'd2, 32'h0,         1'b1, "get_3c"};

    tl_h2d = '0;
    tl_h2d.d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_valid", 32'(tl_d2h.d_valid), 32'd0);
    chk("rst_a_ready", 32'(tl_d2h.a_ready), 32'd1);
    chk("rst_start", 32'(tsen_start), 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      tl_req(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].size,
             vecs[i].exp_d, vecs[i].exp_e, vecs[i].nm, acc);
    end
    drain();

    // One-shot conversion above threshold
    wr(6'h0C, 32'h800, "put_thresh");
    wr(6'h14, 32'h3, "put_ien3");
    drain();
    start_q.delete();
    tl_req(3'd0, 6'h00, 32'h2, 4'hF, 2'd2, 32'h0, 1'b0, "put_ctrl_start", acc);
    repeat (4) @(posedge clk);
    #1;
    man_data = 12'h801;
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("oneshot_pulses", 32'(start_q.size()), 32'd1);
    chk("oneshot_start_cyc", 32'(start_q[0]), 32'(acc + 2));
    chk("oneshot_intr", 32'(intr), 32'd1);
    rd(6'h04, 32'h2, "oneshot_valid");
    rd(6'h08, 32'h801, "oneshot_data");
    rd(6'h04, 32'h0, "oneshot_valid_clr");
    rd(6'h10, 32'h3, "oneshot_istate");
    wr(6'h10, 32'h3, "oneshot_w1c");
    drain();
    chk("oneshot_intr_clr", 32'(intr), 32'd0);

    // Continuous mode with PERIOD=5
    man_data = 12'h100;
    auto_en  = 1'b1;
    start_q.delete();
    tl_req(3'd0, 6'h00, 32'h0005_0001, 4'hF, 2'd2, 32'h0, 1'b0, "put_ctrl_cont", acc);
    drain();
    w = 0;
    while (start_q.size() < 4 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("cont_first", 32'(start_q[0]), 32'(acc + 2));
    for (int i = 0; i < 3; i++) begin
      chk("cont_spacing", 32'(start_q[i+1] - start_q[i]), 32'd10);
    end
    tl_req(3'd0, 6'h00, 32'h0, 4'hF, 2'd2, 32'h0, 1'b0, "put_ctrl_stop", acc2);
    repeat (40) @(posedge clk);
    #1;
    late = 0;
    foreach (start_q[i]) if (start_q[i] >= acc2 + 2) late++;
    chk("cont_stopped", 32'(late), 32'd0);
    auto_en = 1'b0;
    rd(6'h10, 32'h1, "cont_istate_done_only");
    rd(6'h08, 32'h100, "cont_data");
    wr(6'h10, 32'h3, "cont_w1c");
    drain();

    // Timeout: done never arrives
    tl_req(3'd0, 6'h00, 32'h2, 4'hF, 2'd2, 32'h0, 1'b0, "put_ctrl_to", acc);
    goto_cyc(acc + 500);
    rd(6'h04, 32'h1, "to_busy_mid");
    goto_cyc(acc + 1026);
    rd(6'h04, 32'h1, "to_busy_last");
    rd(6'h04, 32'h4, "to_status");
    rd(6'h10, 32'h0, "to_no_done");
    wr(6'h04, 32'h4, "to_w1c");
    rd(6'h04, 32'h0, "to_cleared");
    drain();

    // Backpressure, then back-to-back Put/Get
    tl_h2d.d_ready = 1'b0;
    tl_req(3'd4, 6'h0C, 32'h0, 4'hF, 2'd2, 32'h800, 1'b0, "bp_get_thresh", acc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_d_valid", 32'(tl_d2h.d_valid), 32'd1);
      chk("bp_d_data", tl_d2h.d_data, 32'h800);
      chk("bp_a_ready", 32'(tl_d2h.a_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    tl_h2d.d_ready = 1'b1;
    drained_c.delete();
    wr(6'h14, 32'h1, "b2b_put_ien");
    rd(6'h14, 32'h1, "b2b_get_ien");
    drain();
    chk("b2b_count", 32'(drained_c.size()), 32'd3);
    chk("b2b_rate1", 32'(drained_c[1] - drained_c[0]), 32'd1);
    chk("b2b_rate2", 32'(drained_c[2] - drained_c[1]), 32'd1);

    // Collision: DONE set and W1C of DONE in the same cycle
    tl_req(3'd0, 6'h00, 32'h2, 4'hF, 2'd2, 32'h0, 1'b0, "put_ctrl_col1", acc);
    goto_cyc(acc + 6);
    man_data = 12'h0AB;
    man_done = 1'b1;
    wr(6'h10, 32'h1, "col_w1c_done");
    man_done = 1'b0;
    rd(6'h10, 32'h1, "col_done_wins");
    drain();
    chk("col_intr", 32'(intr), 32'd1);

    // Collision: DATA read in the capture cycle
    tl_req(3'd0, 6'h00, 32'h2, 4'hF, 2'd2, 32'h0, 1'b0, "put_ctrl_col2", acc);
    goto_cyc(acc + 6);
    man_data = 12'h7FF;
    man_done = 1'b1;
    rd(6'h08, 32'h0AB, "col_data_old");
    man_done = 1'b0;
    rd(6'h04, 32'h2, "col_valid_kept");
    rd(6'h08, 32'h7FF, "col_data_new");
    drain();

    // Reset during WAIT with a response pending
    tl_req(3'd0, 6'h00, 32'h2, 4'hF, 2'd2, 32'h0, 1'b0, "put_ctrl_rst", acc);
    goto_cyc(acc + 4);
    tl_h2d.d_ready = 1'b0;
    tl_req(3'd4, 6'h0C, 32'h0, 4'hF, 2'd2, 32'h800, 1'b0, "dropped_get", acc2);
    chk("pre_rst_d_valid", 32'(tl_d2h.d_valid), 32'd1);
    chk("pre_rst_intr", 32'(intr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_d_valid", 32'(tl_d2h.d_valid), 32'd0);
    chk("arst_a_ready", 32'(tl_d2h.a_ready), 32'd1);
    chk("arst_start", 32'(tsen_start), 32'd0);
    chk("arst_intr", 32'(intr), 32'd0);
    exp_q.delete();
    rsp_q.delete();
    @(posedge clk);
    #1;
    tl_h2d.d_ready = 1'b1;
    rst_n = 1'b1;
    start_q.delete();
    @(posedge clk);
    #1;
    rd(6'h04, 32'h0, "post_rst_status");
    rd(6'h0C, 32'hFFF, "post_rst_thresh");
    rd(6'h14, 32'h0, "post_rst_ien");
    rd(6'h10, 32'h0, "post_rst_istate");
    drain();
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_start", 32'(start_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tsen_ctrl.md
# tsen_ctrl

TL-UL device-side controller for an on-die temperature sensor. It sits on a peripheral crossbar device port, currently the unconnected `tsen1` and `tsen2` slots. The block answers TL-UL Get and Put requests to a small register file and sequences sensor conversions: one-shot or periodic, with a timeout. It raises a level interrupt toward the PLIC on conversion-done or over-threshold.

## Interface
Parameters:
- `DataWidth`, default 12: sensor sample width (≤16).
- `TimeoutCycles`, default 1024: maximum cycles from `tsen_start_o` to `tsen_done_i`.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `tl_i`  in  tlul_pkg::tl_h2d_t  request channel A plus `d_ready`.
- `tl_o`  out  tlul_pkg::tl_d2h_t  response channel D plus `a_ready`.
- `tsen_start_o`  out  1  one-cycle conversion start pulse.
- `tsen_done_i`  in  1  conversion complete; sample is valid this cycle.
- `tsen_data_i`  in  DataWidth  sample value.
- `intr_tsen_o`  out  1  level interrupt, `|(INTR_STATE & INTR_ENABLE)`.

## Operation
Register map; offsets are `a_address[5:0]`, upper bits ignored:
- **0x00 CTRL** (RW): `[0]` EN selects continuous mode. `[1]` START is write-1 one-shot and reads 0. `[31:16]` PERIOD is the idle cycle count between samples in continuous mode.
- **0x04 STATUS** (RO): `[0]` BUSY, `[1]` VALID, `[2]` TIMEOUT (sticky, cleared by a write of 1 to this bit).
- **0x08 DATA** (RO): `[DataWidth-1:0]` last sample. Reading it clears VALID.
- **0x0C THRESH** (RW): `[DataWidth-1:0]`, resets to all ones.
- **0x10 INTR_STATE** (W1C): `[0]` DONE, `[1]` HIGH.
- **0x14 INTR_ENABLE** (RW): `[1:0]`.
- Offsets 0x18–0x3F return an error response.

TL-UL responder rules:
- Supported opcodes are Get (4) and PutFullData (0). PutPartialData is accepted only when `a_mask==4'hF`. `a_size` must be 2.
- Any other opcode, size or mask, or an unmapped offset, returns `d_error=1` and `d_data=0`, with no side effect.
- Get returns AccessAckData (1). Put returns AccessAck (0).
- `d_source` and `d_size` echo the request.
- Reserved bits read 0.

Conversion FSM has four states: IDLE, START, WAIT, GAP.
- **IDLE → START**: START written, or EN=1.
- **START**: `tsen_start_o=1` for exactly this one cycle, then → WAIT.
- **WAIT**, on `tsen_done_i`:
  - DATA ← sample, VALID=1, DONE=1.
  - HIGH=1 if sample > THRESH (strict).
  - Next state is GAP if EN=1, else IDLE.
- **WAIT timeout**: if `TimeoutCycles` cycles elapse without done, set TIMEOUT and go → IDLE.
- **GAP**: count down PERIOD, then → START. PERIOD=0 goes → START on the next cycle. If EN=0 in GAP, go → IDLE.
- BUSY=1 in START and WAIT.

## Timing
- `a_ready = !d_valid || d_ready`. The request is accepted on `a_valid && a_ready`.
- The response is registered: `d_valid` rises the cycle after acceptance and holds, with stable content, until `d_ready`. Back-to-back requests sustain 1 per cycle.
- Register writes and read side effects (VALID clear) take effect at the acceptance edge. Read data is sampled from pre-edge register values.
- START takes effect at the acceptance edge, so `tsen_start_o` is high 2 cycles after the acceptance cycle.
- Reset values: `d_valid=0`, `a_ready=1`, `tsen_start_o=0`, `intr_tsen_o=0`, FSM=IDLE. All registers are 0 except THRESH.

Simultaneous events:
- Hardware set and software W1C of the same INTR_STATE bit in one cycle: set wins.
- DATA read in the same cycle as sample capture: the read returns the old value and VALID ends at 1.
- START written while BUSY: ignored. START with EN=1 in GAP: immediate → START.
- EN cleared during WAIT: the sample completes, then → IDLE.
- `tsen_done_i` outside WAIT: ignored.
- Reset mid-conversion or mid-response: all state returns to reset values immediately, and any pending response is dropped.

## Test plan
- **Register reads after reset**: Get at 0x0C returns `0x00000FFF`, `d_opcode=1`, `d_error=0`. Get at 0x20 returns `d_error=1`, `d_data=0`. Put with `a_mask=4'h3` returns AccessAck with `d_error=1`, and the target register is unchanged.
- **One-shot**:
  - Stimulus: THRESH=0x800, INTR_ENABLE=3, write CTRL=0x2.
  - Response: exactly one `tsen_start_o` pulse.
  - Drive `tsen_done_i` with 0x801. Expected: DATA=0x801, INTR_STATE=3, `intr_tsen_o=1`.
  - Read DATA. Expected: STATUS VALID=0.
  - W1C 0x10 with 3. Expected: interrupt low.
- **Continuous mode**:
  - Stimulus: CTRL=0x00050001, done returned 3 cycles after each start.
  - Expected: start pulses 10 cycles apart (1 START + 3 WAIT + 5 GAP + 1).
  - Clear EN. Expected: no further pulses.
- **Timeout**: one-shot with `tsen_done_i` never asserted. Expected: BUSY drops after 1024 cycles, TIMEOUT=1, DONE=0.
- **Backpressure**: hold `d_ready=0` for 5 cycles after a Get. Expected: `d_valid` and `d_data` stable, `a_ready=0` throughout. Then issue a back-to-back Put and Get with `d_ready=1`. Expected: one response per cycle.
- **Collision**:
  - Drive `tsen_done_i` in the same cycle a W1C of DONE is accepted. Expected: DONE=1.
  - Assert `rst_ni` low during WAIT. Expected: all outputs return to reset values asynchronously.
